// File: rtl/cpm_fifo_mc_if.sv
// Bus bundle for the cpm_fifo_mc multi-channel FIFO bank.
// Error flags exist only when CPM_FIFO_MC_ERR_FLAG_EN is defined.
interface cpm_fifo_mc_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_CH     = 4
) ();

  logic [NUM_CH-1:0]                  clear;
  logic [NUM_CH-1:0]                  push;
  logic [NUM_CH-1:0]                  pop;
  logic [NUM_CH*DATA_WIDTH-1:0]       data_in;
  logic [ADDR_WIDTH:0]                af_thresh;
  logic [ADDR_WIDTH:0]                ae_thresh;
  logic [NUM_CH*DATA_WIDTH-1:0]       data_out;
  logic [NUM_CH-1:0]                  empty;
  logic [NUM_CH-1:0]                  full;
  logic [NUM_CH-1:0]                  almost_full;
  logic [NUM_CH-1:0]                  almost_empty;
  logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   fifo_count;
`ifdef CPM_FIFO_MC_ERR_FLAG_EN
  logic [NUM_CH-1:0]                  err_ovf;
  logic [NUM_CH-1:0]                  err_udf;
`endif

  modport master (
    output clear, push, pop, data_in, af_thresh, ae_thresh,
    input  data_out, empty, full, almost_full, almost_empty, fifo_count
`ifdef CPM_FIFO_MC_ERR_FLAG_EN
    , input err_ovf, err_udf
`endif
  );

  modport slave (
    input  clear, push, pop, data_in, af_thresh, ae_thresh,
    output data_out, empty, full, almost_full, almost_empty, fifo_count
`ifdef CPM_FIFO_MC_ERR_FLAG_EN
    , output err_ovf, err_udf
`endif
  );

endinterface

// File: rtl/cpm_fifo_mc.sv
// NUM_CH independent FIFOs with per-channel clear, shared AF/AE thresholds and REG_OUT/FWFT reads.
// Optional sticky overflow/underflow flags when CPM_FIFO_MC_ERR_FLAG_EN is defined.
module cpm_fifo_mc #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_CH     = 4,
  parameter bit          REG_OUT    = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  cpm_fifo_mc_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  full, empty;
    logic                  push_ok, pop_ok;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);

    // Clear suppresses both accepts so memory and read data stay untouched.
    assign push_ok = bus.push[c] & ~full  & ~bus.clear[c];
    assign pop_ok  = bus.pop[c]  & ~empty & ~bus.clear[c];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.clear[c]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        if (push_ok && !pop_ok) begin
          count_d = count_q + CntW'(1);
        end else if (pop_ok && !push_ok) begin
          count_d = count_q - CntW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
        mem_q[wr_ptr_q] <= bus.data_in[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    if (REG_OUT) begin : g_reg_out
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (pop_ok) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign bus.data_out[c*DATA_WIDTH +: DATA_WIDTH] = dout_q;
    end else begin : g_fwft
      // Head entry shown directly; stale contents are visible while empty.
      assign bus.data_out[c*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];
    end

    assign bus.empty[c]                      = empty;
    assign bus.full[c]                       = full;
    assign bus.almost_full[c]                = (count_q >= bus.af_thresh);
    assign bus.almost_empty[c]               = (count_q <= bus.ae_thresh);
    assign bus.fifo_count[c*CntW +: CntW]    = count_q;

`ifdef CPM_FIFO_MC_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
      ovf_d = ovf_q | (bus.push[c] & full);
      udf_d = udf_q | (bus.pop[c] & empty);
      if (bus.clear[c]) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_d;
        udf_q <= udf_d;
      end
    end

    assign bus.err_ovf[c] = ovf_q;
    assign bus.err_udf[c] = udf_q;
`endif
  end

endmodule
